pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage NPC pipeline; complements EX-stage operand forwarding.
//  Detects load-use hazards, holds the pipe across multi-cycle MDU ops and LSU bus waits,
//  kills wrong-path instructions on EX redirects, and tracks in-flight IFU fetches so stale responses are dropped.
// PARAMETERS
//  RA_W      5  register address width
//  MAX_OUT   2  max outstanding IFU fetch requests
//  CNT_W     2  width of outstanding/drop counters (must hold MAX_OUT)
// PORTS
//  clk             in   1      clock; all state on rising edge
//  rst             in   1      synchronous reset, active-high
//  id_valid        in   1      ID holds a valid instruction
//  id_rs1/id_rs2   in   RA_W   ID source register addresses
//  id_rs1_ren/_rs2_ren in 1    ID actually reads rs1/rs2
//  ex_valid        in   1      EX holds a valid instruction
//  ex_rd           in   RA_W   EX destination register
//  ex_reg_wen      in   1      EX instruction writes rd
//  ex_mem_ren      in   1      EX instruction is a load
//  ex_mdu_start    in   1      MUL/DIV issued to MDU this cycle (1-cycle pulse)
//  mdu_done        in   1      MDU result valid (1-cycle pulse)
//  lsu_req         in   1      MEM issues data-bus access this cycle
//  lsu_resp        in   1      data-bus response this cycle
//  ex_redirect     in   1      taken branch/jump resolved in EX
//  ifu_req_fire    in   1      fetch request accepted this cycle
//  ifu_resp_valid  in   1      fetch response arriving this cycle
//  stall_if/id/ex/mem out 1    hold PC / IF-ID / ID-EX / EX-MEM registers
//  bubble_ex       out  1      load NOP into ID/EX
//  bubble_mem      out  1      load NOP into EX/MEM
//  flush_id        out  1      invalidate IF/ID
//  drop_resp       out  1      discard current fetch response
//  ifu_req_allow   out  1      IFU may issue a new fetch
//  dbg_state       out  2      {mdu_pend, state==LSU_WAIT}
// BEHAVIOUR
//  State: FSM {RUN, LSU_WAIT}, flag mdu_pend, counters out_cnt, drop_cnt. Outputs combinational from state+inputs.
//  Reset: state=RUN, mdu_pend=0, out_cnt=0, drop_cnt=0. While rst=1 every output is 0 (incl. ifu_req_allow).
//  mem_wait = (RUN & lsu_req & !lsu_resp) | (LSU_WAIT & !lsu_resp).
//  mdu_wait = (mdu_pend | ex_mdu_start) & !mdu_done.
//  load_use = id_valid & ex_valid & ex_mem_ren & ex_reg_wen & ex_rd!=0 & (rs1 match & ren | rs2 match & ren).
//  redirect = ex_redirect & ex_valid & !stall_ex (otherwise ignored; EX re-presents it later).
//  Priority, highest first:
//   mem_wait : stall_if/id/ex/mem=1; all bubbles/flush=0.
//   mdu_wait : stall_if/id/ex=1, bubble_mem=1.
//   redirect : flush_id=1, bubble_ex=1, stall_*=0 (overrides load_use; ID is wrong-path).
//   load_use : stall_if/id=1, bubble_ex=1 (exactly one bubble; load leaves EX next cycle).
//  FSM: RUN->LSU_WAIT on lsu_req & !lsu_resp; lsu_req+lsu_resp same cycle = 0-wait, stay RUN.
//   LSU_WAIT->RUN on lsu_resp; stall released in the response cycle. lsu_req ignored in LSU_WAIT.
//  mdu_pend: set on ex_mdu_start & !mdu_done, cleared on mdu_done; updates even during LSU_WAIT,
//   so a done captured under mem_wait leaves no MDU stall afterwards.
//  out_cnt' = out_cnt + ifu_req_fire - ifu_resp_valid; saturates at MAX_OUT, never underflows (stray resp ignored).
//  ifu_req_allow = out_cnt < MAX_OUT.
//  On redirect: drop_resp = ifu_resp_valid; drop_cnt' = out_cnt'. Fires in the redirect cycle are wrong-path and counted.
//  Otherwise drop_resp = ifu_resp_valid & drop_cnt!=0; drop_cnt decrements on each dropped response.
//  Reset mid-operation: pending drops and stalls vanish next cycle; IFU/LSU/MDU are reset together.
// TESTING
//  Load x5 in EX, ID reads x5 via rs2 -> one cycle: stall_if=stall_id=bubble_ex=1; next cycle all 0.
//  Load to x0 in EX, ID reads x0 -> no stall; ID rs2_ren=0 with rs2=ex_rd -> no stall.
//  lsu_req, lsu_resp 3 cycles later -> stall_mem=1 for 3 cycles, 0 in resp cycle, dbg_state[0] toggles 0,1,1,1,0.
//  ex_mdu_start + lsu_req same cycle, mdu_done under LSU_WAIT -> after lsu_resp no stalls, mdu_pend=0.
//  out_cnt=2, ex_redirect with resp same cycle -> drop_resp=1 now, next resp dropped, third kept; flush_id=1.
//  ex_redirect during mem_wait -> flush_id=0; re-asserted after lsu_resp -> flush_id=1 that cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU and LSU holds,
// EX redirect flushes, and tracking of in-flight fetches so stale responses are dropped.
module pipeline_hazard_ctrl #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_ren,
  input  logic            id_rs2_ren,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_wen,
  input  logic            ex_mem_ren,
  input  logic            ex_mdu_start,
  input  logic            mdu_done,
  input  logic            lsu_req,
  input  logic            lsu_resp,
  input  logic            ex_redirect,
  input  logic            ifu_req_fire,
  input  logic            ifu_resp_valid,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            stall_mem,
  output logic            bubble_ex,
  output logic            bubble_mem,
  output logic            flush_id,
  output logic            drop_resp,
  output logic            ifu_req_allow,
  output logic [1:0]      dbg_state
);

  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {RUN, LSU_WAIT} state_t;

  state_t           state;
  logic             mdu_pend;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] drop_cnt;

  logic             in_lsu_wait;
  logic             mem_wait;
  logic             mdu_wait;
  logic             load_use;
  logic             redirect;
  logic             drop_now;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic [CNT_W-1:0] drop_cnt_nxt;

  assign in_lsu_wait = (state == LSU_WAIT);
  assign mem_wait    = (!in_lsu_wait && lsu_req && !lsu_resp) || (in_lsu_wait && !lsu_resp);
  assign mdu_wait    = (mdu_pend || ex_mdu_start) && !mdu_done;
  assign load_use    = id_valid && ex_valid && ex_mem_ren && ex_reg_wen && (ex_rd != '0) &&
                       (((id_rs1 == ex_rd) && id_rs1_ren) || ((id_rs2 == ex_rd) && id_rs2_ren));
  // A redirect under any EX hold is ignored; EX presents it again once released.
  assign redirect    = ex_redirect && ex_valid && !(mem_wait || mdu_wait);
  assign drop_now    = redirect ? ifu_resp_valid : (ifu_resp_valid && (drop_cnt != '0));

  // Outstanding-fetch count: saturating, and a response with nothing in flight is ignored.
  always_comb begin
    cnt_sum = {1'b0, out_cnt} + SUM_W'(ifu_req_fire);
    if (ifu_resp_valid && (cnt_sum != '0)) cnt_sum = cnt_sum - SUM_W'(1);
    if (cnt_sum > SUM_W'(MAX_OUT)) cnt_sum = SUM_W'(MAX_OUT);
    out_cnt_nxt = cnt_sum[CNT_W-1:0];
    if (redirect) drop_cnt_nxt = out_cnt_nxt;
    else if (drop_now) drop_cnt_nxt = drop_cnt - CNT_W'(1);
    else drop_cnt_nxt = drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      mdu_pend <= 1'b0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        RUN:      if (lsu_req && !lsu_resp) state <= LSU_WAIT;
        LSU_WAIT: if (lsu_resp) state <= RUN;
        default:  state <= RUN;
      endcase
      if (mdu_done) mdu_pend <= 1'b0;
      else if (ex_mdu_start) mdu_pend <= 1'b1;
      out_cnt  <= out_cnt_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  // Priority: memory wait, MDU wait, redirect, load-use. All outputs quiet in reset.
  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    bubble_ex     = 1'b0;
    bubble_mem    = 1'b0;
    flush_id      = 1'b0;
    drop_resp     = 1'b0;
    ifu_req_allow = 1'b0;
    dbg_state     = 2'b00;
    if (!rst) begin
      if (mem_wait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (mdu_wait) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        stall_ex   = 1'b1;
        bubble_mem = 1'b1;
      end else if (redirect) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      drop_resp     = drop_now;
      ifu_req_allow = (out_cnt < CNT_W'(MAX_OUT));
      dbg_state     = {mdu_pend, in_lsu_wait};
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected output vectors are queued as each
// step is driven and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_ren, id_rs2_ren;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_reg_wen, ex_mem_ren, ex_mdu_start, mdu_done;
  logic       lsu_req, lsu_resp, ex_redirect, ifu_req_fire, ifu_resp_valid;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem;
  logic       flush_id, drop_resp, ifu_req_allow;
  logic [1:0] dbg_state;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .lsu_req(lsu_req), .lsu_resp(lsu_resp), .ex_redirect(ex_redirect),
    .ifu_req_fire(ifu_req_fire), .ifu_resp_valid(ifu_resp_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_id(flush_id),
    .drop_resp(drop_resp), .ifu_req_allow(ifu_req_allow), .dbg_state(dbg_state)
  );

  // {stall_if,id,ex,mem, bubble_ex, bubble_mem, flush_id, drop_resp, ifu_req_allow, dbg_state}
  function automatic logic [10:0] mk(input logic [3:0] st, input logic bex, input logic bmem,
                                     input logic fl, input logic dr, input logic al,
                                     input logic [1:0] dbg);
    return {st, bex, bmem, fl, dr, al, dbg};
  endfunction

  localparam logic [10:0] IDLE = 11'b0000_0000_100;

  task automatic clr();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_ren = 0; id_rs2_ren = 0;
    ex_valid = 0; ex_rd = '0; ex_reg_wen = 0; ex_mem_ren = 0; ex_mdu_start = 0; mdu_done = 0;
    lsu_req = 0; lsu_resp = 0; ex_redirect = 0; ifu_req_fire = 0; ifu_resp_valid = 0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    ex_valid = 1; ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = rd;
  endtask

  // Queue the expectation for the current inputs, compare at negedge, then advance a cycle.
  task automatic step(input string tag, input logic [10:0] e);
    logic [10:0] obs, want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
            flush_id, drop_resp, ifu_req_allow, dbg_state};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%b expected=%b", t, obs, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    lsu_req = 1; load_in_ex(5'd5); id_valid = 1; id_rs1 = 5'd5; id_rs1_ren = 1;
    step("reset_quiet", 11'b0);
    clr(); rst = 0;
    step("idle", IDLE);

    // load-use via rs2, then released
    load_in_ex(5'd5); id_valid = 1; id_rs2 = 5'd5; id_rs2_ren = 1;
    step("load_use_rs2", mk(4'b1100, 1, 0, 0, 0, 1, 2'b00));
    clr(); id_valid = 1; id_rs2 = 5'd5; id_rs2_ren = 1;
    step("load_use_release", IDLE);
    clr(); load_in_ex(5'd0); id_valid = 1; id_rs1 = 5'd0; id_rs1_ren = 1;
    step("load_x0", IDLE);
    clr(); load_in_ex(5'd7); id_valid = 1; id_rs2 = 5'd7; id_rs2_ren = 0;
    step("rs2_not_read", IDLE);
    clr(); load_in_ex(5'd9); id_valid = 1; id_rs1 = 5'd9; id_rs1_ren = 1;
    step("load_use_rs1", mk(4'b1100, 1, 0, 0, 0, 1, 2'b00));

    // LSU wait of 3 cycles
    clr(); lsu_req = 1;
    step("lsu_req", mk(4'b1111, 0, 0, 0, 0, 1, 2'b00));
    clr();
    step("lsu_wait1", mk(4'b1111, 0, 0, 0, 0, 1, 2'b01));
    step("lsu_wait2", mk(4'b1111, 0, 0, 0, 0, 1, 2'b01));
    lsu_resp = 1;
    step("lsu_resp", mk(4'b0000, 0, 0, 0, 0, 1, 2'b01));
    clr();
    step("lsu_after", IDLE);
    lsu_req = 1; lsu_resp = 1;
    step("lsu_zero_wait", IDLE);
    clr();
    step("lsu_zero_after", IDLE);

    // MDU hold
    ex_mdu_start = 1;
    step("mdu_start", mk(4'b1110, 0, 1, 0, 0, 1, 2'b00));
    clr();
    step("mdu_pend", mk(4'b1110, 0, 1, 0, 0, 1, 2'b10));
    ex_valid = 1; ex_redirect = 1;
    step("redirect_under_mdu", mk(4'b1110, 0, 1, 0, 0, 1, 2'b10));
    clr(); mdu_done = 1;
    step("mdu_done", mk(4'b0000, 0, 0, 0, 0, 1, 2'b10));
    clr();
    step("mdu_after", IDLE);

    // MDU done captured while the LSU holds
    ex_mdu_start = 1; lsu_req = 1;
    step("mdu_lsu_start", mk(4'b1111, 0, 0, 0, 0, 1, 2'b00));
    clr(); mdu_done = 1;
    step("mdu_done_in_lsu", mk(4'b1111, 0, 0, 0, 0, 1, 2'b11));
    clr(); lsu_resp = 1;
    step("mdu_lsu_resp", mk(4'b0000, 0, 0, 0, 0, 1, 2'b01));
    clr();
    step("mdu_lsu_after", IDLE);

    // Redirect with two fetches in flight, overriding a load-use
    ifu_req_fire = 1;
    step("fire1", IDLE);
    step("fire2", IDLE);
    clr(); ex_valid = 1; ex_redirect = 1; ifu_resp_valid = 1;
    ex_mem_ren = 1; ex_reg_wen = 1; ex_rd = 5'd3; id_valid = 1; id_rs1 = 5'd3; id_rs1_ren = 1;
    step("redirect_drop_now", mk(4'b0000, 1, 0, 1, 1, 0, 2'b00));
    clr(); ifu_resp_valid = 1;
    step("drop_second", mk(4'b0000, 0, 0, 0, 1, 1, 2'b00));
    clr(); ifu_req_fire = 1;
    step("fire_new", IDLE);
    clr(); ifu_resp_valid = 1;
    step("keep_third", IDLE);

    // Redirect blocked under mem_wait, honoured in response cycle
    clr(); lsu_req = 1; ex_valid = 1; ex_redirect = 1;
    step("redirect_blocked", mk(4'b1111, 0, 0, 0, 0, 1, 2'b00));
    lsu_req = 0; lsu_resp = 1;
    step("redirect_on_resp", mk(4'b0000, 1, 0, 1, 0, 1, 2'b01));

    // Stray response must not underflow; saturation blocks fetch
    clr(); ifu_resp_valid = 1;
    step("stray_resp", IDLE);
    clr();
    step("no_underflow", IDLE);
    ifu_req_fire = 1;
    step("sat_fire1", IDLE);
    step("sat_fire2", IDLE);
    clr();
    step("sat_full", mk(4'b0000, 0, 0, 0, 0, 0, 2'b00));

    // Reset mid-operation clears drops, stalls and flags
    ex_valid = 1; ex_redirect = 1;
    step("pre_reset_redirect", mk(4'b0000, 1, 0, 1, 0, 0, 2'b00));
    clr(); lsu_req = 1; ex_mdu_start = 1;
    step("pre_reset_lsu", mk(4'b1111, 0, 0, 0, 0, 0, 2'b00));
    clr(); rst = 1;
    step("reset_mid", 11'b0);
    rst = 0; ifu_resp_valid = 1;
    step("post_reset_no_drop", IDLE);
    clr();
    step("post_reset_idle", IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
